usb_txn_ctrl: RTL and testbench

- Host-side transaction sequencer that drives the USB datapath's packet interface.
- Accepts one OUT or IN request at a time and sequences token, data and handshake packets through the encoder, then turns the bus around (re) to collect the device response from the decoder.
- Handles timeout, NAK and CRC-error retries, and keeps per-endpoint DATA0/DATA1 toggle state.

---
 rtl/usb_txn_if.sv | 41 ++++
 rtl/usb_txn_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_usb_txn_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_txn_if.sv
// Packet and request bundle between the host transaction sequencer
// and its requester / USB datapath.
interface usb_txn_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_dir;
  logic [6:0]   req_addr;
  logic [3:0]   req_endp;
  logic [63:0]  req_data;
  logic         done;
  logic [1:0]   status;
  logic [63:0]  rsp_data;
  logic [98:0]  pkt_in;
  logic         pkt_in_avail;
  logic         encoder_ready;
  logic         re;
  logic [98:0]  pkt_out;
  logic         pkt_out_avail;
  logic         data_good;
  logic         decoder_ready;

  modport slave (
    input  req_valid, req_dir, req_addr,
    input  req_endp, req_data,
    output req_ready, done, status, rsp_data,
    output pkt_in, pkt_in_avail, re,
    input  encoder_ready, pkt_out,
    input  pkt_out_avail, data_good,
    input  decoder_ready
  );

  modport master (
    output req_valid, req_dir, req_addr,
    output req_endp, req_data,
    input  req_ready, done, status, rsp_data,
    input  pkt_in, pkt_in_avail, re,
    output encoder_ready, pkt_out,
    output pkt_out_avail, data_good,
    output decoder_ready
  );
endinterface

// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: token/data/handshake sequencing,
// retries on timeout/NAK/CRC, and per-endpoint DATA0/DATA1 toggles.
module usb_txn_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input logic      clk,
  input logic      rst_b,
  usb_txn_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1
                    : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TO  = 2'b01;
  localparam logic [1:0] ST_NAK = 2'b10;
  localparam logic [1:0] ST_CRC = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_TOKEN, S_DATA_TX,
    S_WAIT_HS, S_WAIT_DATA,
    S_SEND_ACK, S_SEND_ACK_RETRY,
    S_RETRY, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SND_REQ, SND_LO, SND_HI
  } snd_e;

  function automatic logic [98:0] tok_pkt(
    input logic       in_dir,
    input logic [6:0] a,
    input logic [3:0] e
  );
    return {in_dir ? PID_IN : PID_OUT,
            a, e, 80'd0};
  endfunction

  function automatic logic [98:0] dat_pkt(
    input logic [7:0]  pid,
    input logic [63:0] d
  );
    return {pid, d, 27'd0};
  endfunction

  function automatic logic [98:0] hs_pkt(
    input logic [7:0] pid
  );
    return {pid, 91'd0};
  endfunction

  state_e        state_q, state_d;
  snd_e          snd_q, snd_d;
  logic          dir_q, dir_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    endp_q, endp_d;
  logic [63:0]   data_q, data_d;
  logic [15:0]   tog_q, tog_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cause_q, cause_d;
  logic [1:0]    status_q, status_d;
  logic [63:0]   rsp_q, rsp_d;
  logic [98:0]   pkt_q, pkt_d;
  logic          avail_q, avail_d;
  logic          re_q, re_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;

  logic          send_done;
  logic [7:0]    rx_pid;
  logic [7:0]    exp_pid;
  logic [7:0]    oth_pid;

  assign rx_pid  = bus.pkt_out[98:91];
  assign exp_pid = tog_q[endp_q] ? PID_DATA1
                                 : PID_DATA0;
  assign oth_pid = tog_q[endp_q] ? PID_DATA0
                                 : PID_DATA1;

  always_comb begin
    state_d   = state_q;
    snd_d     = snd_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    data_d    = data_q;
    tog_d     = tog_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    cause_d   = cause_q;
    status_d  = status_q;
    rsp_d     = rsp_q;
    pkt_d     = pkt_q;
    avail_d   = avail_q;
    ready_d   = ready_q;
    send_done = 1'b0;

    // accept, then wait for the encoder to go busy and idle again
    if (state_q inside {S_TOKEN, S_DATA_TX,
                        S_SEND_ACK,
                        S_SEND_ACK_RETRY}) begin
      unique case (snd_q)
        SND_REQ:
          if (bus.encoder_ready) begin
            avail_d = 1'b0;
            snd_d   = SND_LO;
          end
        SND_LO:
          if (!bus.encoder_ready)
            snd_d = SND_HI;
        SND_HI:
          if (bus.encoder_ready) begin
            send_done = 1'b1;
            snd_d     = SND_REQ;
          end
        default: snd_d = SND_REQ;
      endcase
    end

    unique case (state_q)
      S_IDLE:
        if (bus.req_valid) begin
          dir_d   = bus.req_dir;
          addr_d  = bus.req_addr;
          endp_d  = bus.req_endp;
          data_d  = bus.req_data;
          retry_d = '0;
          ready_d = 1'b0;
          pkt_d   = tok_pkt(bus.req_dir,
                            bus.req_addr,
                            bus.req_endp);
          avail_d = 1'b1;
          state_d = S_TOKEN;
        end
      S_TOKEN:
        if (send_done) begin
          if (dir_q) begin
            timer_d = '0;
            state_d = S_WAIT_DATA;
          end else begin
            pkt_d   = dat_pkt(exp_pid, data_q);
            avail_d = 1'b1;
            state_d = S_DATA_TX;
          end
        end
      S_DATA_TX:
        if (send_done) begin
          timer_d = '0;
          state_d = S_WAIT_HS;
        end
      S_WAIT_HS:
        if (bus.pkt_out_avail) begin
          if (bus.data_good &&
              rx_pid == PID_ACK) begin
            tog_d[endp_q] = ~tog_q[endp_q];
            status_d = ST_OK;
            state_d  = S_DONE;
          end else if (bus.data_good &&
                       rx_pid == PID_NAK) begin
            cause_d = ST_NAK;
            state_d = S_RETRY;
          end else begin
            cause_d = ST_CRC;
            state_d = S_RETRY;
          end
        end else if (timer_q == TMAX) begin
          cause_d = ST_TO;
          state_d = S_RETRY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      S_WAIT_DATA:
        if (bus.pkt_out_avail) begin
          if (!bus.data_good) begin
            cause_d = ST_CRC;
            state_d = S_RETRY;
          end else if (rx_pid == exp_pid) begin
            rsp_d   = bus.pkt_out[90:27];
            tog_d[endp_q] = ~tog_q[endp_q];
            pkt_d   = hs_pkt(PID_ACK);
            avail_d = 1'b1;
            state_d = S_SEND_ACK;
          end else if (rx_pid == oth_pid) begin
            // duplicate: device missed our ACK
            cause_d = ST_CRC;
            pkt_d   = hs_pkt(PID_ACK);
            avail_d = 1'b1;
            state_d = S_SEND_ACK_RETRY;
          end else if (rx_pid == PID_NAK) begin
            cause_d = ST_NAK;
            state_d = S_RETRY;
          end else begin
            cause_d = ST_CRC;
            state_d = S_RETRY;
          end
        end else if (timer_q == TMAX) begin
          cause_d = ST_TO;
          state_d = S_RETRY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      S_SEND_ACK:
        if (send_done) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end
      S_SEND_ACK_RETRY:
        if (send_done)
          state_d = S_RETRY;
      S_RETRY:
        if (retry_q == RMAX) begin
          status_d = cause_q;
          state_d  = S_DONE;
        end else begin
          retry_d = retry_q + 1'b1;
          pkt_d   = tok_pkt(dir_q, addr_q,
                            endp_q);
          avail_d = 1'b1;
          state_d = S_TOKEN;
        end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    re_d   = (state_d == S_WAIT_HS) ||
             (state_d == S_WAIT_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q  <= S_IDLE;
      snd_q    <= SND_REQ;
      dir_q    <= 1'b0;
      addr_q   <= '0;
      endp_q   <= '0;
      data_q   <= '0;
      tog_q    <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      cause_q  <= ST_OK;
      status_q <= ST_OK;
      rsp_q    <= '0;
      pkt_q    <= '0;
      avail_q  <= 1'b0;
      re_q     <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      snd_q    <= snd_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      endp_q   <= endp_d;
      data_q   <= data_d;
      tog_q    <= tog_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      cause_q  <= cause_d;
      status_q <= status_d;
      rsp_q    <= rsp_d;
      pkt_q    <= pkt_d;
      avail_q  <= avail_d;
      re_q     <= re_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.done         = done_q;
  assign bus.status       = status_q;
  assign bus.rsp_data     = rsp_q;
  assign bus.pkt_in       = pkt_q;
  assign bus.pkt_in_avail = avail_q;
  assign bus.re           = re_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Scoreboard bench for usb_txn_ctrl: a transaction-level model predicts
// encoder packets and completion results; monitors compare.
`timescale 1ns/1ps
module tb_usb_txn_ctrl;

  localparam int TIMEOUT   = 255;
  localparam int MAX_RETRY = 3;

  localparam logic [7:0] P_OUT = 8'hE1;
  localparam logic [7:0] P_IN  = 8'h69;
  localparam logic [7:0] P_D0  = 8'hC3;
  localparam logic [7:0] P_D1  = 8'h4B;
  localparam logic [7:0] P_ACK = 8'hD2;
  localparam logic [7:0] P_NAK = 8'h5A;

  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_NAK  = 2;
  localparam int K_BAD  = 3;
  localparam int K_EXP  = 4;
  localparam int K_DUP  = 5;

  typedef struct {
    bit          none;
    bit          good;
    logic [98:0] pkt;
    int          dly;
  } rsp_t;

  typedef struct {
    logic [1:0]  st;
    bit          chk;
    logic [63:0] rsp;
  } res_t;

  logic clk = 1'b0;
  logic rst_b = 1'b1;

  usb_txn_if bus();

  usb_txn_ctrl #(
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int ovl    = 0;

  logic [98:0] pkt_q[$];
  res_t        res_q[$];
  bit          tog[16];
  res_t        mon_r;

  function automatic logic [98:0] tok(
    input logic [7:0] pid,
    input logic [6:0] a,
    input logic [3:0] e
  );
    return {pid, a, e, 80'd0};
  endfunction

  function automatic logic [98:0] dat(
    input logic [7:0]  pid,
    input logic [63:0] d
  );
    return {pid, d, 27'd0};
  endfunction

  function automatic logic [98:0] hs(
    input logic [7:0] pid
  );
    return {pid, 91'd0};
  endfunction

  task automatic chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  task automatic bail(input string nm);
    checks++;
    $display("FAIL %s: wait bound expired", nm);
    $display("%0d/%0d checks passed",
             passes, checks);
    $fatal(1, "stopped after expired wait");
  endtask

  task automatic wait_re(
    input bit    lvl,
    input int    lim,
    input string nm
  );
    int n = 0;
    while (bus.re !== lvl) begin
      @(negedge clk);
      n++;
      if (n > lim) bail(nm);
    end
  endtask

  task automatic wait_rdy(input string nm);
    int n = 0;
    while (bus.req_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 300) bail(nm);
    end
  endtask

  function automatic int rand_kind(input bit dir);
    int r = $urandom_range(0, 99);
    if (r < 4) return K_NONE;
    if (!dir) begin
      if (r < 55) return K_ACK;
      if (r < 75) return K_NAK;
      if (r < 90) return K_BAD;
      return K_DUP;
    end
    if (r < 55) return K_EXP;
    if (r < 70) return K_NAK;
    if (r < 82) return K_BAD;
    return K_DUP;
  endfunction

  // encoder model and packet scoreboard
  initial begin
    bus.encoder_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.pkt_in_avail &&
          bus.encoder_ready) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.encoder_ready = 1'b0;
          repeat ($urandom_range(1, 2))
            @(negedge clk);
          bus.encoder_ready = 1'b1;
        end
        if (pkt_q.size() == 0) begin
          checks++;
          $display("FAIL enc_pkt: got %h want none",
                   bus.pkt_in);
        end else begin
          chk("enc_pkt", bus.pkt_in,
              pkt_q.pop_front());
        end
        @(negedge clk);
        bus.encoder_ready = 1'b0;
        repeat ($urandom_range(1, 3))
          @(negedge clk);
        bus.encoder_ready = 1'b1;
      end
    end
  end

  // completion monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.re && bus.pkt_in_avail) ovl++;
      if (bus.done) begin
        if (res_q.size() == 0) begin
          checks++;
          $display("FAIL done: got pulse want none");
        end else begin
          mon_r = res_q.pop_front();
          chk("status", bus.status, mon_r.st);
          if (mon_r.chk)
            chk("rsp_data", bus.rsp_data,
                mon_r.rsp);
        end
      end
    end
  end

  task automatic issue(
    input bit          dir,
    input logic [6:0]  a,
    input logic [3:0]  e,
    input logic [63:0] d
  );
    wait_rdy("req_ready");
    bus.req_valid = 1'b1;
    bus.req_dir   = dir;
    bus.req_addr  = a;
    bus.req_endp  = e;
    bus.req_data  = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_dir   = 1'($urandom);
    bus.req_addr  = 7'($urandom);
    bus.req_endp  = 4'($urandom);
    bus.req_data  = {$urandom, $urandom};
  endtask

  // kinds: up to 4 scripted responses (4 bits each), rest random
  task automatic run_txn(
    input bit          dir,
    input logic [6:0]  a,
    input logic [3:0]  e,
    input logic [63:0] d,
    input int          nk,
    input logic [15:0] ks,
    input logic [63:0] fixp
  );
    rsp_t        scr[$];
    rsp_t        s;
    res_t        r;
    logic [1:0]  cause = 2'b00;
    bit          ok = 0;
    int          k;
    int          n;
    logic [7:0]  ep;
    logic [7:0]  op;
    logic [63:0] pay;
    r.chk = 0;
    r.rsp = '0;
    for (int at = 0;
         at <= MAX_RETRY && !ok; at++) begin
      ep  = tog[e] ? P_D1 : P_D0;
      op  = tog[e] ? P_D0 : P_D1;
      k   = (at < nk) ? int'(ks[at*4 +: 4])
                      : rand_kind(dir);
      pay = {$urandom, $urandom};
      pkt_q.push_back(
        tok(dir ? P_IN : P_OUT, a, e));
      if (!dir) pkt_q.push_back(dat(ep, d));
      s.none = 0;
      s.good = 1;
      s.pkt  = '0;
      s.dly  = ($urandom_range(0, 15) == 0)
             ? TIMEOUT : $urandom_range(0, 6);
      case (k)
        K_NONE: begin
          s.none = 1;
          cause  = 2'b01;
        end
        K_ACK: begin
          s.pkt = hs(P_ACK);
          if (!dir) begin
            ok     = 1;
            tog[e] = !tog[e];
          end else cause = 2'b11;
        end
        K_NAK: begin
          s.pkt = hs(P_NAK);
          cause = 2'b10;
        end
        K_BAD: begin
          s.pkt  = dir ? dat(ep, pay) : hs(P_ACK);
          s.good = 0;
          cause  = 2'b11;
        end
        K_EXP: begin
          if (fixp != 0) pay = fixp;
          s.pkt = dat(ep, pay);
          if (dir) begin
            ok     = 1;
            tog[e] = !tog[e];
            r.chk  = 1;
            r.rsp  = pay;
            pkt_q.push_back(hs(P_ACK));
          end else cause = 2'b11;
        end
        default: begin
          s.pkt = dat(op, pay);
          if (dir) pkt_q.push_back(hs(P_ACK));
          cause = 2'b11;
        end
      endcase
      scr.push_back(s);
    end
    r.st = ok ? 2'b00 : cause;
    res_q.push_back(r);

    issue(dir, a, e, d);
    // stray decoder output outside a receive window
    if ($urandom_range(0, 3) == 0) begin
      bus.pkt_out       = hs(P_ACK);
      bus.data_good     = 1'b1;
      bus.pkt_out_avail = 1'b1;
      @(negedge clk);
      bus.pkt_out_avail = 1'b0;
    end
    foreach (scr[i]) begin
      wait_re(1'b1, 200, "re_rise");
      if (scr[i].none) begin
        n = 0;
        while (bus.re) begin
          n++;
          @(negedge clk);
          if (n > TIMEOUT + 10) bail("re_hold");
        end
        chk("timeout_len", n, TIMEOUT + 1);
      end else begin
        repeat (scr[i].dly) @(negedge clk);
        bus.pkt_out       = scr[i].pkt;
        bus.data_good     = scr[i].good;
        bus.pkt_out_avail = 1'b1;
        @(negedge clk);
        bus.pkt_out_avail = 1'b0;
        bus.data_good     = 1'($urandom);
        bus.pkt_out       = {$urandom, $urandom,
                             $urandom, $urandom};
        wait_re(1'b0, 4, "re_fall");
      end
    end
    wait_rdy("done_wait");
  endtask

  task automatic reset_mid(
    input logic [6:0] a,
    input logic [3:0] e
  );
    logic [63:0] d = {$urandom, $urandom};
    pkt_q.push_back(tok(P_OUT, a, e));
    pkt_q.push_back(dat(tog[e] ? P_D1 : P_D0, d));
    issue(1'b0, a, e, d);
    wait_re(1'b1, 200, "rst_re_rise");
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_mid_re", bus.re, 1'b0);
    chk("rst_mid_ready", bus.req_ready, 1'b1);
    chk("rst_mid_done", bus.done, 1'b0);
    rst_b = 1'b0;
    foreach (tog[i]) tog[i] = 0;
  endtask

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_dir       = 1'b0;
    bus.req_addr      = '0;
    bus.req_endp      = '0;
    bus.req_data      = '0;
    bus.pkt_out       = '0;
    bus.pkt_out_avail = 1'b0;
    bus.data_good     = 1'b0;
    bus.decoder_ready = 1'b1;
    foreach (tog[i]) tog[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_status", bus.status, 2'b00);
    chk("rst_rsp", bus.rsp_data, 64'd0);
    chk("rst_pkt", bus.pkt_in, 99'd0);
    chk("rst_avail", bus.pkt_in_avail, 1'b0);
    chk("rst_re", bus.re, 1'b0);
    rst_b = 1'b0;
    @(negedge clk);

    run_txn(0, 7'd5, 4'd2,
            64'h0123456789ABCDEF,
            1, 16'(K_ACK), 64'd0);
    run_txn(0, 7'd5, 4'd2, {$urandom, $urandom},
            1, 16'(K_ACK), 64'd0);
    run_txn(1, 7'd9, 4'd1, 64'd0,
            1, 16'(K_EXP),
            64'hDEADBEEF00000000);
    run_txn(0, 7'd3, 4'd6, 64'hA5A5,
            4, {4'(K_NONE), 4'(K_NONE),
                4'(K_NONE), 4'(K_NONE)}, 64'd0);
    run_txn(1, 7'd4, 4'd3, 64'd0,
            3, {4'd0, 4'(K_EXP),
                4'(K_NAK), 4'(K_NAK)}, 64'd0);
    run_txn(1, 7'd4, 4'd4, 64'd0,
            3, {4'd0, 4'(K_EXP),
                4'(K_DUP), 4'(K_BAD)}, 64'd0);
    run_txn(1, 7'd8, 4'd5, 64'd0,
            4, {4'(K_NAK), 4'(K_NAK),
                4'(K_NAK), 4'(K_NAK)}, 64'd0);
    run_txn(0, 7'd8, 4'd5, 64'h77,
            4, {4'(K_BAD), 4'(K_DUP),
                4'(K_BAD), 4'(K_NAK)}, 64'd0);
    reset_mid(7'd9, 4'd1);
    run_txn(0, 7'd9, 4'd1, 64'h1234,
            1, 16'(K_ACK), 64'd0);
    run_txn(1, 7'd9, 4'd4, 64'd0,
            1, 16'(K_EXP), 64'd0);

    for (int t = 0; t < 40; t++)
      run_txn(1'($urandom), 7'($urandom),
              4'($urandom_range(0, 3)),
              {$urandom, $urandom},
              0, 16'd0, 64'd0);

    repeat (10) @(negedge clk);
    chk("re_avail_excl", ovl, 0);
    chk("pkt_q_empty", pkt_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("%0d/%0d checks passed",
             passes, checks);
    $finish;
  end

endmodule
